mem_arbiter: RTL

- Shares the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RISC-V core.
- Accepts line-sized requests from both caches and grants one at a time, using alternating priority when both request together.
- Holds each request stable on the memory port until the memory responds, then returns a one-cycle response to the winning cache.
- Sits between the I-cache/D-cache controllers and the memory model. The IF and MEM pipeline stages stall while their cache waits.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester line arbiter: shares one memory port between the I-cache and D-cache miss paths.
// Alternating priority on ties; each request is held on the memory port until mem_resp, then acknowledged once.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   // state   | meaning
   // IDLE    | arbitrate pending requests
   // SERVE_I | I-cache read outstanding on memory port
   // SERVE_D | D-cache read or writeback outstanding
   // RESP_I  | one-cycle i_resp pulse
   // RESP_D  | one-cycle d_resp pulse
   typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

   state_t                state, state_nxt;
   logic                  last_d, last_d_nxt;
   logic                  mem_read_nxt, mem_write_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [LINE_WIDTH-1:0] mem_wdata_nxt;
   logic [LINE_WIDTH-1:0] i_rdata_nxt, d_rdata_nxt;
   logic                  i_resp_nxt, d_resp_nxt;
   logic                  d_req, grant_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_resp    <= 1'b0;
         d_resp    <= 1'b0;
      end else begin
         state     <= state_nxt;
         last_d    <= last_d_nxt;
         mem_read  <= mem_read_nxt;
         mem_write <= mem_write_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         i_rdata   <= i_rdata_nxt;
         d_rdata   <= d_rdata_nxt;
         i_resp    <= i_resp_nxt;
         d_resp    <= d_resp_nxt;
      end
   end

   // D wins a tie unless it was the last one served; after reset last_d=0 so D wins first.
   assign d_req   = d_read | d_write;
   assign grant_d = d_req & (~i_read | ~last_d);

   always_comb begin
      state_nxt     = state;
      last_d_nxt    = last_d;
      mem_read_nxt  = mem_read;
      mem_write_nxt = mem_write;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      i_rdata_nxt   = i_rdata;
      d_rdata_nxt   = d_rdata;
      i_resp_nxt    = 1'b0;
      d_resp_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt     = SERVE_D;
               last_d_nxt    = 1'b1;
               mem_addr_nxt  = d_addr;
               mem_wdata_nxt = d_wdata;
               mem_write_nxt = d_write;
               mem_read_nxt  = ~d_write;
            end else if (i_read) begin
               state_nxt    = SERVE_I;
               last_d_nxt   = 1'b0;
               mem_addr_nxt = i_addr;
               mem_read_nxt = 1'b1;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               state_nxt    = RESP_I;
               i_rdata_nxt  = mem_rdata;
               mem_read_nxt = 1'b0;
               i_resp_nxt   = 1'b1;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               state_nxt = RESP_D;
               if (mem_read) d_rdata_nxt = mem_rdata;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = 1'b0;
               d_resp_nxt    = 1'b1;
            end
         end
         RESP_I:  state_nxt = IDLE;
         RESP_D:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
